// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the FIFO write-side controller: FSM encoding, Gray quadrants, bin2gray.
// The HOLD state only exists when FIFO_WR_HOLD_EN is defined.
package fifo_wr_ctrl_pkg;

`ifdef FIFO_WR_HOLD_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        HOLD  = 2'b10
    } wr_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01
    } wr_state_e;
`endif

    // Two MSBs of the Gray pointer walk these quadrants; the async comparator
    // infers direction (filling vs draining) from the quadrant relationship.
    localparam logic [1:0] Q1 = 2'b00;
    localparam logic [1:0] Q2 = 2'b01;
    localparam logic [1:0] Q3 = 2'b11;
    localparam logic [1:0] Q4 = 2'b10;

    // Width-agnostic up to 32 bits; callers zero-extend in and truncate out.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary/Gray write-pointer register pair; both advance together on inc.
module fifo_gray_ptr
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         wclk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    logic [W-1:0] bin_nxt;

    assign bin_nxt = bin + W'(1);

    // Gray is registered directly so the comparator never sees a multi-bit glitch.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else if (inc) begin
            bin  <= bin_nxt;
            gray <= W'(bin2gray(32'(bin_nxt)));
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: accepts one request per two cycles, writes RAM, then advances wptr.
// Define FIFO_WR_HOLD_EN to park requests that arrive while full instead of dropping them.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_rdy,
    output logic                  wr_ack,
    input  logic                  fifo_full,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] wptr,
    input  logic                  ovf_clr,
    output logic                  overflow,
    output wr_state_e             state_dbg
);

    // Handshake: wr_rdy is high only in IDLE; a request is taken when
    // wr_req & wr_rdy and the accept condition holds, and wr_ack marks that
    // same cycle. Requests seen while wr_rdy is low are ignored, not queued.

    wr_state_e             state, state_nxt;
    logic [ADDR_WIDTH-1:0] bptr;
    logic                  ptr_inc;
    logic                  capture;
    logic                  drop;

    fifo_gray_ptr #(.W(ADDR_WIDTH)) u_ptr (
        .wclk (wclk),
        .rst  (rst),
        .inc  (ptr_inc),
        .bin  (bptr),
        .gray (wptr)
    );

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_rdy    = 1'b0;
        wr_ack    = 1'b0;
        ram_we    = 1'b0;
        ptr_inc   = 1'b0;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) begin
                    if (!fifo_full) begin
                        wr_ack    = 1'b1;
                        capture   = 1'b1;
                        state_nxt = WRITE;
                    end else begin
`ifdef FIFO_WR_HOLD_EN
                        wr_ack    = 1'b1;
                        capture   = 1'b1;
                        state_nxt = HOLD;
`else
                        drop      = 1'b1;
`endif
                    end
                end
            end
            // wptr advances on the same edge that closes the RAM write cycle.
            WRITE: begin
                ram_we    = 1'b1;
                ptr_inc   = 1'b1;
                state_nxt = IDLE;
            end
`ifdef FIFO_WR_HOLD_EN
            HOLD: begin
                if (!fifo_full) state_nxt = WRITE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Address can be latched at accept time: nothing else moves bptr before WRITE.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else if (capture) begin
            ram_waddr <= bptr;
            ram_wdata <= wr_data;
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8); follows FIFO_WR_HOLD_EN like the RTL.
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;
    import fifo_wr_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          wclk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          wr_rdy;
    logic          wr_ack;
    logic          fifo_full;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] wptr;
    logic          ovf_clr;
    logic          overflow;
    wr_state_e     state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    m_bptr;
    logic [DW-1:0]    m_last_data;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .wclk      (wclk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .wr_ack    (wr_ack),
        .fifo_full (fifo_full),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .wptr      (wptr),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [AW-1:0] gray_of(input logic [AW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [1:0] next_quadrant(input logic [1:0] q);
        case (q)
            Q1:      return Q2;
            Q2:      return Q3;
            Q3:      return Q4;
            default: return Q1;
        endcase
    endfunction

    // Pops the scoreboard when the DUT shows a RAM write.
    task automatic sb_ram_write();
        logic [AW+DW-1:0] e;
        check("ram_we", ram_we, 1);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("ram_waddr", ram_waddr, e[AW+DW-1:DW]);
            check("ram_wdata", ram_wdata, e[DW-1:0]);
        end
    endtask

    // Closing edge of a WRITE cycle: model pointer advances, Gray properties checked.
    task automatic close_write(input logic [AW-1:0] prev_g);
        tick();
        m_bptr = m_bptr + 1'b1;
        check("ram_we_off", ram_we, 0);
        check("wptr", wptr, gray_of(m_bptr));
        check("gray_1bit", $countones(wptr ^ prev_g), 1);
        if (wptr[AW-1:AW-2] != prev_g[AW-1:AW-2])
            check("quadrant", wptr[AW-1:AW-2], next_quadrant(prev_g[AW-1:AW-2]));
        if (prev_g == 4'b1000)
            check("wrap", wptr, 4'b0000);
        check("hold_wdata", ram_wdata, m_last_data);
    endtask

    task automatic do_write(input logic [DW-1:0] data, input bit poke_in_write);
        logic [AW-1:0] prev_g;
        int n;
        n = 0;
        while (!wr_rdy && n < 8) begin
            tick();
            n++;
        end
        check("rdy_wait", wr_rdy, 1);
        wr_req  = 1'b1;
        wr_data = data;
        #1;
        check("wr_ack", wr_ack, 1);
        exp_q.push_back({m_bptr, data});
        m_last_data = data;
        tick();
        wr_req = 1'b0;
        if (poke_in_write) begin
            wr_req  = 1'b1;
            wr_data = ~data;
            #1;
            check("ack_in_write", wr_ack, 0);
            check("rdy_in_write", wr_rdy, 0);
        end
        sb_ram_write();
        check("wptr_not_early", wptr, gray_of(m_bptr));
        prev_g = wptr;
        close_write(prev_g);
        wr_req = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] pg;
        rst = 1'b1; wr_req = 1'b0; wr_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;
        m_bptr = '0; m_last_data = '0;
        repeat (2) tick();
        check("rst_state", state_dbg, IDLE);
        check("rst_wptr", wptr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_waddr", ram_waddr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdy", wr_rdy, 1);
        rst = 1'b0;
        tick();

        // first three writes: explicit Gray values
        do_write(8'h11, 1'b0);
        check("wptr_w1", wptr, 4'b0001);
        do_write(8'h22, 1'b0);
        check("wptr_w2", wptr, 4'b0011);
        do_write(8'h33, 1'b0);
        check("wptr_w3", wptr, 4'b0010);

        // request during WRITE ignored, next IDLE request taken
        do_write(8'h44, 1'b1);
        do_write(8'h55, 1'b0);
        check("no_ovf_poke", overflow, 0);

`ifdef FIFO_WR_HOLD_EN
        fifo_full = 1'b1;
        wr_req = 1'b1; wr_data = 8'h3C;
        #1;
        check("hold_ack", wr_ack, 1);
        exp_q.push_back({m_bptr, 8'h3C});
        m_last_data = 8'h3C;
        tick();
        wr_req = 1'b0;
        check("hold_state", state_dbg, HOLD);
        repeat (2) begin
            tick();
            check("hold_no_we", ram_we, 0);
        end
        fifo_full = 1'b0;
        begin
            int n;
            n = 0;
            while (!ram_we && n < 4) begin
                tick();
                n++;
            end
        end
        pg = wptr;
        sb_ram_write();
        close_write(pg);
        check("hold_no_ovf", overflow, 0);
`else
        fifo_full = 1'b1;
        wr_req = 1'b1; wr_data = 8'hA5;
        #1;
        check("full_no_ack", wr_ack, 0);
        tick();
        wr_req = 1'b0;
        check("full_no_we", ram_we, 0);
        check("full_ovf", overflow, 1);
        check("full_wdata_kept", ram_wdata, m_last_data);
        check("full_wptr_kept", wptr, gray_of(m_bptr));
        wr_req = 1'b1; ovf_clr = 1'b1;
        tick();
        wr_req = 1'b0;
        check("ovf_set_prio", overflow, 1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        fifo_full = 1'b0;
`endif

        // reset in WRITE at bptr=5
        while (m_bptr != 4'd5) do_write(8'($urandom_range(0, 255)), 1'b0);
        wr_req = 1'b1; wr_data = 8'h6E;
        #1;
        check("rst_case_ack", wr_ack, 1);
        exp_q.push_back({m_bptr, 8'h6E});
        tick();
        wr_req = 1'b0;
        sb_ram_write();
        #2 rst = 1'b1;
        #1;
        check("abort_we", ram_we, 0);
        check("abort_wptr", wptr, 4'b0000);
        check("abort_waddr", ram_waddr, 0);
        check("abort_state", state_dbg, IDLE);
        tick();
        rst = 1'b0;
        m_bptr = '0; m_last_data = '0;
        tick();
        do_write(8'h77, 1'b0);
        check("after_abort_wptr", wptr, 4'b0001);

        // 32 random writes through two wraps
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_write(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        check("sb_drained", exp_q.size(), 0);
        check("final_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
